// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: fixed wait states, one-cycle response pulse.
// Optional byte-lane strobes are enabled with DMEM_BYTE_STROBE_EN.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   input  logic        i_req_write,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  i_req_be,
`endif
   output logic        o_req_ready,
   output logic        o_stall_M,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err
);

   localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          r_state, w_state_d;
   logic [3:0]      r_cnt, w_cnt_d;
   logic            r_write;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [3:0]      r_be;
   logic            r_resp_valid;
   logic [31:0]     r_resp_rdata;
   logic            r_resp_err;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic            w_accept;
   logic            w_enter_resp;
   logic [3:0]      w_in_be;
   logic            w_acc_write;
   logic [31:0]     w_acc_addr;
   logic            w_err;
   logic [IdxW-1:0] w_idx;

`ifdef DMEM_BYTE_STROBE_EN
   assign w_in_be = i_req_be;
`else
   assign w_in_be = 4'hF;
`endif

   assign w_accept = (r_state == StIdle) && i_req_valid;

   // With zero wait states RESP is entered straight from IDLE, so decode the live request there.
   assign w_acc_write = (r_state == StIdle) ? i_req_write : r_write;
   assign w_acc_addr  = (r_state == StIdle) ? i_req_addr  : r_addr;
   assign w_idx       = w_acc_addr[IdxW+1:2];
   assign w_err       = (|w_acc_addr[1:0]) || (|w_acc_addr[31:IdxW+2]);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_req_valid) begin
               w_cnt_d = CntInit;
               if (WAIT_CYCLES == 0) w_state_d = StResp;
               else                  w_state_d = StWait;
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) w_state_d = StResp;
            else               w_cnt_d   = r_cnt - 4'd1;
         end
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   assign w_enter_resp = (w_state_d == StResp) && (r_state != StResp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_accept) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_be    <= w_in_be;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= w_enter_resp;
         r_resp_err   <= w_enter_resp && w_err;
         // Store responses leave the previous load data in place.
         if (w_enter_resp && !w_acc_write) begin
            r_resp_rdata <= w_err ? 32'd0 : r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '{default: '0};
      end else if ((r_state == StResp) && r_write && !w_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

   assign o_req_ready  = (r_state == StIdle);
   assign o_stall_M    = w_accept || (r_state == StWait);
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store requests issued by the pipelined core's MEM stage. Accepts one request at a time, models a fixed number of wait states, and returns read data or a write acknowledgement with a one-cycle response pulse. Drives a stall request into the core's hazard logic so the MEM stage holds until the response cycle. Sits beside the core top as the target end of the core's data-memory interface.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- WAIT_CYCLES, 2: wait states between acceptance and response; 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  core presents a load/store; held stable while stall_M=1.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte-lane write enables; present only with DMEM_BYTE_STROBE_EN.
- req_ready  out  1  1 only in IDLE.
- stall_M  out  1  combinational stall request to the hazard logic.
- resp_valid  out  1  one-cycle response pulse, registered.
- resp_rdata  out  32  load data, registered; holds its value between responses.
- resp_err  out  1  error flag, registered; 0 whenever resp_valid=0.

## Operation
- Three states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, latch req_write, req_addr, req_wdata, and req_be. Go to WAIT if WAIT_CYCLES>0, else go to RESP. Load the wait counter with WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. At 0, go to RESP. req_* inputs are ignored.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_valid in this cycle is ignored, because the core still presents the same request until the pipeline advances at this edge.
- stall_M = (IDLE && req_valid) || WAIT. It is 0 in RESP, so the MEM stage advances at the end of the RESP cycle.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2].
- An error occurs when addr[1:0]!=0 (misaligned) or any addr bit above the index range is 1. On error:
  - resp_err=1.
  - A store is discarded.
  - A load returns resp_rdata=0.
- Store with no error: memory is written at the RESP edge. Load: resp_rdata is registered on entering RESP.
- A load immediately after a store to the same word returns the stored value.
- Reset is asynchronous, mid-operation included:
  - state=IDLE, counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - All memory words cleared to 0.
  - Any in-flight store is not performed.
- Reset values: req_ready=1. stall_M follows req_valid.

## Timing
- Request accepted in cycle T (IDLE with req_valid=1). resp_valid=1 in cycle T+WAIT_CYCLES+1.
- stall_M=1 in cycles T..T+WAIT_CYCLES. stall_M=0 in the response cycle.
- Back-to-back: the next request is accepted at T+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=0: accept at T, respond at T+1, stall_M=1 only in cycle T.
- Counter width is 4 bits. No wrap occurs, because the counter is only loaded from IDLE.

## Configuration
- DMEM_BYTE_STROBE_EN defined:
  - req_be port exists.
  - A store writes only the byte lanes with req_be[i]=1.
  - req_be=0 is a legal no-op store: no error, no write.
  - Misalignment is still checked on addr[1:0].
- DMEM_BYTE_STROBE_EN undefined:
  - No req_be port.
  - Every error-free store writes all 32 bits.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load from 0x10. WAIT_CYCLES=2: resp_valid at T+3 for each access, load resp_rdata=0xDEADBEEF, resp_err=0, stall_M high for exactly 3 cycles per access.
- WAIT_CYCLES=0: hold req_valid continuously over 4 alternating store/load pairs to addresses 0x0..0xC. Responses occur every 2 cycles, loads return the stored data, and no request is dropped or duplicated.
- Load from 0x11 (misaligned) and from 0x400 with DEPTH_WORDS=256 (out of range): resp_err=1 and resp_rdata=0 for both. A prior store to 0x400 leaves word 0 unchanged.
- Assert rst_n low during WAIT of a store of 0x12345678 to 0x20, then load 0x20: resp_rdata=0, and resp_valid never pulsed for the aborted store.
- With DMEM_BYTE_STROBE_EN: store 0xFFFFFFFF with be=0xF, then 0x00000000 with be=0x5, then load: resp_rdata=0xFF00FF00.
- resp_valid never exceeds 1 cycle. resp_err=0 whenever resp_valid=0. req_ready=0 outside IDLE across a random request stream.
